// File: rtl/axi_xbar_pkg.sv
// Shared types and constants for the AXI crossbar slave-side W scheduling.
package axi_xbar_pkg;

    localparam int W_LEN_W     = 4;
    localparam int ENT_MST_W   = 2;
    localparam int ENT_ID_W    = 4;

    function automatic int mst_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sized for the crossbar build: up to 4 masters, 4-bit IDs.
    typedef struct packed {
        logic [ENT_MST_W-1:0] mst;
        logic [W_LEN_W-1:0]   len;
        logic [ENT_ID_W-1:0]  id;
    } w_sched_ent_t;

endpackage

// File: rtl/axi_ostd_fifo.sv
// Synchronous outstanding-transaction FIFO with count/full/empty.
module axi_ostd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rptr_q];
    assign count   = cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wptr_d = wptr_q + PTR_W'(do_push);
        rptr_d = rptr_q + PTR_W'(do_pop);
        cnt_d  = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (srst) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/axi_slv_w_sched.sv
// Slave-port W scheduler: forwards whole W bursts in AW grant order,
// generates wlast from awlen and flags master wlast/wid disagreement.
module axi_slv_w_sched
    import axi_xbar_pkg::*;
#(
    parameter int NUM_MST    = 3,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 32,
    parameter int OSTD_DEPTH = 4,
    parameter int MST_IDX_W  = mst_idx_w(NUM_MST)
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             srst,
    input  logic                             awgnt_valid,
    output logic                             awgnt_ready,
    input  logic [MST_IDX_W-1:0]             awgnt_mst,
    input  logic [3:0]                       awgnt_len,
    input  logic [AXI_ID_W-1:0]              awgnt_id,
    input  logic [NUM_MST-1:0]               m_wvalid,
    output logic [NUM_MST-1:0]               m_wready,
    input  logic [NUM_MST-1:0]               m_wlast,
    input  logic [NUM_MST*AXI_ID_W-1:0]      m_wid,
    input  logic [NUM_MST*AXI_DATA_W-1:0]    m_wdata,
    input  logic [NUM_MST*AXI_DATA_W/8-1:0]  m_wstrb,
    output logic                             s_wvalid,
    input  logic                             s_wready,
    output logic                             s_wlast,
    output logic [AXI_ID_W-1:0]              s_wid,
    output logic [AXI_DATA_W-1:0]            s_wdata,
    output logic [AXI_DATA_W/8-1:0]          s_wstrb,
    output logic [$clog2(OSTD_DEPTH):0]      ostd_cnt,
    output logic                             err_wlast,
    output logic                             err_wid
);

    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int CNT_W  = $clog2(OSTD_DEPTH) + 1;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_e;

    state_e               state_q, state_d;
    logic [W_LEN_W-1:0]   beat_q, beat_d;
    logic                 err_wlast_q, err_wlast_d;
    logic                 err_wid_q, err_wid_d;

    w_sched_ent_t         push_ent, head_ent;
    logic                 push, pop, fifo_full, fifo_empty;
    logic                 active, hs, last_hs;
    logic [MST_IDX_W-1:0] h;
    logic [AXI_ID_W-1:0]  head_id;

    logic                 sel_wvalid, sel_wlast;
    logic [AXI_ID_W-1:0]  sel_wid;
    logic [AXI_DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0]    sel_wstrb;

    always_comb begin
        push_ent     = '0;
        push_ent.mst = ENT_MST_W'(awgnt_mst);
        push_ent.len = awgnt_len;
        push_ent.id  = ENT_ID_W'(awgnt_id);
    end

    // Ready comes from the registered count: a full FIFO refuses a push
    // even when the head burst retires in the same cycle.
    assign awgnt_ready = ~fifo_full;
    assign push        = awgnt_valid & awgnt_ready;
    assign pop         = last_hs;

    axi_ostd_fifo #(
        .WIDTH ($bits(w_sched_ent_t)),
        .DEPTH (OSTD_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .push    (push),
        .wdata   (push_ent),
        .pop     (pop),
        .rdata   (head_ent),
        .count   (ostd_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign h       = MST_IDX_W'(head_ent.mst);
    assign head_id = AXI_ID_W'(head_ent.id);
    assign active  = (state_q == ST_BURST) & ~fifo_empty;

    always_comb begin
        sel_wvalid = 1'b0;
        sel_wlast  = 1'b0;
        sel_wid    = '0;
        sel_wdata  = '0;
        sel_wstrb  = '0;
        m_wready   = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (active && (h == MST_IDX_W'(i))) begin
                sel_wvalid  = m_wvalid[i];
                sel_wlast   = m_wlast[i];
                sel_wid     = m_wid[i*AXI_ID_W +: AXI_ID_W];
                sel_wdata   = m_wdata[i*AXI_DATA_W +: AXI_DATA_W];
                sel_wstrb   = m_wstrb[i*STRB_W +: STRB_W];
                m_wready[i] = s_wready;
            end
        end
    end

    assign s_wvalid = sel_wvalid;
    assign s_wlast  = active & (beat_q == head_ent.len);
    assign s_wid    = sel_wid;
    assign s_wdata  = sel_wdata;
    assign s_wstrb  = sel_wstrb;
    assign hs       = s_wvalid & s_wready;
    assign last_hs  = hs & s_wlast;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        err_wlast_d = hs & (sel_wlast != s_wlast);
        err_wid_d   = hs & (sel_wid != head_id);
        unique case (state_q)
            ST_IDLE: begin
                if (push || !fifo_empty) state_d = ST_BURST;
            end
            ST_BURST: begin
                if (last_hs && ostd_cnt == CNT_W'(1) && !push)
                    state_d = ST_IDLE;
            end
        endcase
        if (last_hs) begin
            beat_d = '0;
        end else if (hs) begin
            beat_d = beat_q + W_LEN_W'(1);
        end
        if (srst) begin
            state_d     = ST_IDLE;
            beat_d      = '0;
            err_wlast_d = 1'b0;
            err_wid_d   = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            err_wlast_q <= 1'b0;
            err_wid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            err_wlast_q <= err_wlast_d;
            err_wid_q   <= err_wid_d;
        end
    end

    assign err_wlast = err_wlast_q;
    assign err_wid   = err_wid_q;

endmodule

// File: tb/tb_axi_slv_w_sched.sv
// Bench for axi_slv_w_sched: grant-ordered beat model with per-master
// beat queues, directed scenarios followed by random traffic.
module tb_axi_slv_w_sched;

    localparam int NM  = 3;
    localparam int IDW = 4;
    localparam int DW  = 32;
    localparam int SW  = 4;

    logic            aclk, aresetn, srst;
    logic            awgnt_valid, awgnt_ready;
    logic [1:0]      awgnt_mst;
    logic [3:0]      awgnt_len;
    logic [IDW-1:0]  awgnt_id;
    logic [NM-1:0]   m_wvalid, m_wready, m_wlast;
    logic [NM*IDW-1:0] m_wid;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM*SW-1:0]  m_wstrb;
    logic            s_wvalid, s_wready, s_wlast;
    logic [IDW-1:0]  s_wid;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic [2:0]      ostd_cnt;
    logic            err_wlast, err_wid;

    axi_slv_w_sched #(
        .NUM_MST    (NM),
        .AXI_ID_W   (IDW),
        .AXI_DATA_W (DW),
        .OSTD_DEPTH (4)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .srst        (srst),
        .awgnt_valid (awgnt_valid),
        .awgnt_ready (awgnt_ready),
        .awgnt_mst   (awgnt_mst),
        .awgnt_len   (awgnt_len),
        .awgnt_id    (awgnt_id),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_wlast     (m_wlast),
        .m_wid       (m_wid),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .s_wvalid    (s_wvalid),
        .s_wready    (s_wready),
        .s_wlast     (s_wlast),
        .s_wid       (s_wid),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .ostd_cnt    (ostd_cnt),
        .err_wlast   (err_wlast),
        .err_wid     (err_wid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [SW-1:0]  strb;
        logic [IDW-1:0] id;
        logic           last;
        logic [1:0]     mst;
        logic [4:0]     idx;
    } beat_t;

    beat_t expq [$];
    beat_t mq [NM][$];
    int    mcnt;
    logic  pend_ewl, pend_ewid;
    logic [4:0] corrupt_idx;
    logic  corrupt_wid;
    logic  vrand;
    int    tests, fails, hs_total;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cycle(input logic gv, input logic [1:0] gm,
                             input logic [3:0] gl, input logic [IDW-1:0] gid,
                             input logic [NM-1:0] vmask, input logic sr,
                             input logic rs, output logic acc);
        beat_t b;
        logic act, hs, dl;
        logic [1:0] h;
        logic [IDW-1:0] dw;
        logic [NM-1:0] exp_mr;
        awgnt_valid = gv;
        awgnt_mst   = gm;
        awgnt_len   = gl;
        awgnt_id    = gid;
        s_wready    = sr;
        srst        = rs;
        for (int i = 0; i < NM; i++) begin
            if (mq[i].size() != 0 && vmask[i] &&
                (!vrand || $urandom_range(0, 3) != 0)) begin
                b = mq[i][0];
                m_wvalid[i] = 1'b1;
                m_wdata[i*DW +: DW] = b.data;
                m_wstrb[i*SW +: SW] = b.strb;
                m_wid[i*IDW +: IDW] = corrupt_wid ? ~b.id : b.id;
                m_wlast[i] = b.last | (b.idx == corrupt_idx);
            end else begin
                m_wvalid[i] = 1'b0;
                m_wdata[i*DW +: DW] = $urandom;
                m_wstrb[i*SW +: SW] = '0;
                m_wid[i*IDW +: IDW] = '0;
                m_wlast[i] = 1'b0;
            end
        end
        #2;
        act = (expq.size() != 0);
        h   = act ? expq[0].mst : 2'd0;
        dl  = m_wlast[h];
        dw  = m_wid[h*IDW +: IDW];
        chk("ostd_cnt", ostd_cnt, mcnt);
        chk("awgnt_ready", awgnt_ready, mcnt != 4);
        chk("err_wlast", err_wlast, pend_ewl);
        chk("err_wid", err_wid, pend_ewid);
        exp_mr = '0;
        if (act) exp_mr[h] = sr;
        chk("m_wready", m_wready, exp_mr);
        chk("s_wvalid", s_wvalid, act && m_wvalid[h]);
        if (act) chk("s_wlast", s_wlast, expq[0].last);
        hs = act && m_wvalid[h] && sr;
        if (act && m_wvalid[h]) begin
            chk("s_wdata", s_wdata, expq[0].data);
            chk("s_wstrb", s_wstrb, expq[0].strb);
            chk("s_wid", s_wid, dw);
        end
        acc = gv && (mcnt != 4) && !rs;
        @(posedge aclk);
        #1;
        if (rs) begin
            expq.delete();
            for (int i = 0; i < NM; i++) mq[i].delete();
            mcnt = 0;
            pend_ewl = 1'b0;
            pend_ewid = 1'b0;
        end else begin
            pend_ewl  = hs && (dl != expq[0].last);
            pend_ewid = hs && (dw != expq[0].id);
            if (hs) begin
                if (expq[0].last) mcnt--;
                hs_total++;
                void'(expq.pop_front());
                void'(mq[h].pop_front());
            end
            if (acc) begin
                mcnt++;
                for (int k = 0; k <= int'(gl); k++) begin
                    b.data = $urandom;
                    b.strb = SW'($urandom);
                    b.id   = gid;
                    b.last = (k == int'(gl));
                    b.mst  = gm;
                    b.idx  = 5'(k);
                    expq.push_back(b);
                    mq[gm].push_back(b);
                end
            end
        end
    endtask

    task automatic drain(input int maxc, input logic rnd_ready);
        logic a;
        int n;
        n = 0;
        while (mcnt != 0 && n < maxc) begin
            run_cycle(1'b0, 2'd0, 4'd0, '0, '1,
                      rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, a);
            n++;
        end
        chk("drain_done", mcnt, 0);
    endtask

    initial begin
        logic acc;
        int h0;
        tests = 0; fails = 0; hs_total = 0; mcnt = 0;
        pend_ewl = 1'b0; pend_ewid = 1'b0;
        corrupt_idx = 5'h1F; corrupt_wid = 1'b0; vrand = 1'b0;
        aresetn = 1'b0; srst = 1'b0;
        awgnt_valid = 1'b0; awgnt_mst = '0; awgnt_len = '0; awgnt_id = '0;
        m_wvalid = '0; m_wlast = '0; m_wid = '0; m_wdata = '0; m_wstrb = '0;
        s_wready = 1'b1;
        #3;
        chk("rst_s_wvalid", s_wvalid, 0);
        chk("rst_s_wlast", s_wlast, 0);
        chk("rst_s_wid", s_wid, 0);
        chk("rst_s_wdata", s_wdata, 0);
        chk("rst_s_wstrb", s_wstrb, 0);
        chk("rst_m_wready", m_wready, 0);
        chk("rst_ostd_cnt", ostd_cnt, 0);
        chk("rst_awgnt_ready", awgnt_ready, 1);
        chk("rst_err", {err_wlast, err_wid}, 0);
        #10 aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Two queued bursts then back-to-back data.
        run_cycle(1'b1, 2'd1, 4'd3, 4'hA, 3'b000, 1'b1, 1'b0, acc);
        run_cycle(1'b1, 2'd0, 4'd0, 4'h5, 3'b000, 1'b1, 1'b0, acc);
        chk("t1_cnt2", ostd_cnt, 2);
        h0 = hs_total;
        for (int i = 0; i < 5; i++)
            run_cycle(1'b0, 2'd0, 4'd0, '0, 3'b011, 1'b1, 1'b0, acc);
        chk("t1_beats", hs_total - h0, 5);
        chk("t1_cnt0", ostd_cnt, 0);

        // Fill grant FIFO, fifth grant waits for first burst to retire.
        for (int i = 0; i < 4; i++)
            run_cycle(1'b1, 2'(i % 3), 4'(i), 4'(i + 1), 3'b000, 1'b1, 1'b0, acc);
        chk("t2_full_cnt", ostd_cnt, 4);
        chk("t2_full_ready", awgnt_ready, 0);
        run_cycle(1'b1, 2'd2, 4'd1, 4'h7, 3'b000, 1'b1, 1'b0, acc);
        chk("t2_no_accept", awgnt_ready, 0);
        acc = 1'b0;
        for (int i = 0; i < 64 && !acc; i++)
            run_cycle(1'b1, 2'd2, 4'd1, 4'h7, 3'b111, 1'b1, 1'b0, acc);
        chk("t2_accept", acc, 1);
        drain(200, 1'b0);

        // Head m0 idle while m2 has data.
        run_cycle(1'b1, 2'd0, 4'd1, 4'h3, 3'b000, 1'b1, 1'b0, acc);
        run_cycle(1'b1, 2'd2, 4'd0, 4'h9, 3'b000, 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++)
            run_cycle(1'b0, 2'd0, 4'd0, '0, 3'b100, 1'b1, 1'b0, acc);
        chk("t3_m2_ready", m_wready[2], 0);
        drain(50, 1'b0);

        // Early wlast from m1, then a wrong wid from m2.
        corrupt_idx = 5'd1;
        run_cycle(1'b1, 2'd1, 4'd3, 4'hC, 3'b000, 1'b1, 1'b0, acc);
        h0 = hs_total;
        drain(50, 1'b0);
        chk("t4_beats", hs_total - h0, 4);
        corrupt_idx = 5'h1F;
        corrupt_wid = 1'b1;
        run_cycle(1'b1, 2'd2, 4'd1, 4'h6, 3'b000, 1'b1, 1'b0, acc);
        drain(50, 1'b0);
        corrupt_wid = 1'b0;
        run_cycle(1'b0, 2'd0, 4'd0, '0, 3'b000, 1'b1, 1'b0, acc);

        // Long burst under random backpressure.
        run_cycle(1'b1, 2'd2, 4'd15, 4'hE, 3'b000, 1'b1, 1'b0, acc);
        h0 = hs_total;
        vrand = 1'b1;
        drain(400, 1'b1);
        chk("t5_hs16", hs_total - h0, 16);
        vrand = 1'b0;

        // Synchronous reset mid-burst.
        run_cycle(1'b1, 2'd1, 4'd3, 4'h2, 3'b000, 1'b1, 1'b0, acc);
        run_cycle(1'b0, 2'd0, 4'd0, '0, 3'b111, 1'b1, 1'b0, acc);
        run_cycle(1'b0, 2'd0, 4'd0, '0, 3'b111, 1'b1, 1'b0, acc);
        run_cycle(1'b0, 2'd0, 4'd0, '0, 3'b000, 1'b1, 1'b1, acc);
        m_wvalid = 3'b111;
        s_wready = 1'b1;
        srst = 1'b0;
        #1;
        chk("t6_s_wvalid", s_wvalid, 0);
        chk("t6_m_wready", m_wready, 0);
        chk("t6_cnt", ostd_cnt, 0);
        chk("t6_ready", awgnt_ready, 1);
        run_cycle(1'b0, 2'd0, 4'd0, '0, 3'b000, 1'b1, 1'b0, acc);

        // Random grants and traffic.
        vrand = 1'b1;
        for (int i = 0; i < 400; i++)
            run_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                      4'($urandom_range(0, 7)), 4'($urandom),
                      '1, 1'($urandom_range(0, 1)), 1'b0, acc);
        drain(1000, 1'b1);
        vrand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
